transfer_sequencer: RTL and testbench

Sequences register-to-register and immediate-to-register moves on the shared 16-bit S-bus. It sits directly upstream of the per-register 16-bit holding circuits. It drives the S-bus data and the one-hot per-register select (SRx) those circuits consume. Transfer requests from the control unit are buffered in a 2-entry FIFO and executed one at a time by a small FSM.

---
 rtl/transfer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_transfer_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : transfer_sequencer
// Purpose  : Buffers register/immediate move requests in a 2-entry FIFO and
//            drives them one at a time onto the S-bus with a one-hot SRx
//            load select for the downstream holding circuits.
// Revision : 1.0 - initial release
// ============================================================================
module transfer_sequencer #(
  parameter int NREG  = 8,
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_imm,
  input  logic [IDXW-1:0]  req_src,
  input  logic [IDXW-1:0]  req_dst,
  input  logic [WIDTH-1:0] req_data,
  output logic [IDXW-1:0]  rd_sel,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] sbus,
  output logic [NREG-1:0]  sr_sel,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO (two entries, pointer based)
  // --------------------------------------------------------------------------
  logic             fifo_imm  [2];
  logic [IDXW-1:0]  fifo_src  [2];
  logic [IDXW-1:0]  fifo_dst  [2];
  logic [WIDTH-1:0] fifo_data [2];

  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  logic push;
  logic pop;

  logic             head_imm;
  logic [IDXW-1:0]  head_src;
  logic [IDXW-1:0]  head_dst;
  logic [WIDTH-1:0] head_data;
  logic             fifo_empty;

  // Ready depends only on the registered count, never on the pop decision.
  assign req_ready  = ~rst & (count_q < 2'd2);
  assign push       = req_valid & req_ready;
  assign fifo_empty = (count_q == 2'd0);

  assign head_imm  = fifo_imm[rd_ptr_q];
  assign head_src  = fifo_src[rd_ptr_q];
  assign head_dst  = fifo_dst[rd_ptr_q];
  assign head_data = fifo_data[rd_ptr_q];

  // FIFO storage: written on accept, no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_imm[wr_ptr_q]  <= req_imm;
      fifo_src[wr_ptr_q]  <= req_src;
      fifo_dst[wr_ptr_q]  <= req_dst;
      fifo_data[wr_ptr_q] <= req_data;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] hold_q;
  logic [IDXW-1:0]  dst_q;
  logic [IDXW-1:0]  rd_sel_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pop decision; IDLE and DRIVE both start the next queued op.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DRIVE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = head_imm ? ST_DRIVE : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_DRIVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Current-op datapath: hold value, destination and read-mux select.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      dst_q    <= '0;
      rd_sel_q <= '0;
    end else begin
      if (pop) begin
        dst_q <= head_dst;
        if (head_imm) hold_q   <= head_data;
        else          rd_sel_q <= head_src;
      end else if (state_q == ST_FETCH) begin
        hold_q <= rd_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registers, none from the request port.
  // --------------------------------------------------------------------------
  assign rd_sel = rd_sel_q;
  assign sbus   = hold_q;
  assign done   = (state_q == ST_DRIVE);
  assign busy   = ~fifo_empty | (state_q != ST_IDLE);

  // One-hot decode; destinations at or above NREG select nothing.
  generate
    for (genvar i = 0; i < NREG; i++) begin : g_sr_sel
      assign sr_sel[i] = (state_q == ST_DRIVE) && (dst_q == IDXW'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transfer_sequencer
// Purpose  : Self-checking bench for transfer_sequencer: directed vector table,
//            burst / mixed / reset-abort sequences, and a randomized run
//            checked against a queue-based transfer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transfer_sequencer;

  localparam int NREG  = 8;
  localparam int WIDTH = 16;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_imm;
  logic [IDXW-1:0]  req_src;
  logic [IDXW-1:0]  req_dst;
  logic [WIDTH-1:0] req_data;
  logic [IDXW-1:0]  rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] sbus;
  logic [NREG-1:0]  sr_sel;
  logic             done;
  logic             busy;

  int tests = 0;
  int fails = 0;

  transfer_sequencer #(.NREG(NREG), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_imm(req_imm), .req_src(req_src), .req_dst(req_dst), .req_data(req_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .sbus(sbus), .sr_sel(sr_sel), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file behind the read mux; loads from the S-bus on sr_sel.
  logic [WIDTH-1:0] rf [NREG];
  logic             pl_en = 1'b0;
  logic [IDXW-1:0]  pl_idx = '0;
  logic [WIDTH-1:0] pl_val = '0;
  assign rd_data = rf[rd_sel];

  // Register file update: preload from bench or capture from S-bus.
  always @(posedge clk) begin
    if (pl_en) rf[pl_idx] <= pl_val;
    for (int i = 0; i < NREG; i++)
      if (sr_sel[i]) rf[i] <= sbus;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic imm, input logic [IDXW-1:0] src,
                           input logic [IDXW-1:0] dst, input logic [WIDTH-1:0] data);
    req_valid = 1'b1; req_imm = imm; req_src = src; req_dst = dst; req_data = data;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // Directed single-transfer vectors from an idle, empty block.
  typedef struct {
    logic             imm;
    logic [IDXW-1:0]  src;
    logic [IDXW-1:0]  dst;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] rfval;
    logic [WIDTH-1:0] exp_sbus;
    logic [NREG-1:0]  exp_sel;
    int               lat;
  } vec_t;
  vec_t vecs [6];

  typedef struct {
    logic             imm;
    logic [IDXW-1:0]  src;
    logic [IDXW-1:0]  dst;
    logic [WIDTH-1:0] data;
  } op_t;

  // Four back-to-back ops with req_valid held; checks order, values, spacing.
  task automatic burst(input logic imm, input string tag);
    int n_acc = 0, n_done = 0, saw_full = 0;
    logic [WIDTH-1:0] got_v [4];
    logic [NREG-1:0]  got_s [4];
    int               got_c [4];
    int               spacing;
    spacing = imm ? 1 : 2;
    if (!imm)
      for (int i = 0; i < 4; i++) preload(IDXW'(i), WIDTH'(16'hB0 + i));
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        if (n_done < 4) begin
          got_v[n_done] = sbus; got_s[n_done] = sr_sel; got_c[n_done] = c;
        end
        n_done++;
      end
      if (!req_ready) saw_full = 1;
      if (n_acc < 4) begin
        if (imm) drive_req(1'b1, '0, IDXW'(n_acc), WIDTH'(16'hA0 + n_acc));
        else     drive_req(1'b0, IDXW'(n_acc), IDXW'(n_acc + 4), '0);
      end else req_valid = 1'b0;
      if (req_valid && req_ready) n_acc++;
      tick();
    end
    req_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(n_acc), 32'd4);
    chk({tag, "_done_count"}, 32'(n_done), 32'd4);
    for (int i = 0; i < 4 && i < n_done; i++) begin
      chk({tag, "_sbus"}, 32'(got_v[i]), imm ? 32'(16'hA0 + i) : 32'(16'hB0 + i));
      chk({tag, "_sr_sel"}, 32'(got_s[i]), 32'(8'h1 << (imm ? i : i + 4)));
      if (i > 0) chk({tag, "_spacing"}, 32'(got_c[i] - got_c[i-1]), 32'(spacing));
    end
    if (!imm) chk({tag, "_ready_dropped"}, 32'(saw_full), 32'd1);
  endtask

  logic [WIDTH-1:0] ref_rf [NREG];
  op_t              q [$];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_imm = 1'b0;
    req_src = '0; req_dst = '0; req_data = '0;
    for (int i = 0; i < NREG; i++) rf[i] = '0;

    vecs[0] = '{1'b1, 3'd0, 3'd5, 16'h1234, 16'h0000, 16'h1234, 8'h20, 1};
    vecs[1] = '{1'b0, 3'd2, 3'd7, 16'h0000, 16'hBEEF, 16'hBEEF, 8'h80, 2};
    vecs[2] = '{1'b1, 3'd6, 3'd0, 16'hFFFF, 16'h0000, 16'hFFFF, 8'h01, 1};
    vecs[3] = '{1'b0, 3'd3, 3'd3, 16'h0000, 16'h0F0F, 16'h0F0F, 8'h08, 2};
    vecs[4] = '{1'b1, 3'd1, 3'd7, 16'h0000, 16'h0000, 16'h0000, 8'h80, 1};
    vecs[5] = '{1'b0, 3'd0, 3'd1, 16'h0000, 16'hA5A5, 16'hA5A5, 8'h02, 2};

    // Reset then idle.
    do_reset();
    chk("rst_sr_sel", 32'(sr_sel), 32'd0);
    chk("rst_sbus", 32'(sbus), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_sel", 32'(rd_sel), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].imm) preload(vecs[v].src, vecs[v].rfval);
      drive_req(vecs[v].imm, vecs[v].src, vecs[v].dst, vecs[v].data);
      chk("vec_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      chk("vec_busy_c0", 32'(busy), 32'd1);
      for (int n = 1; n <= vecs[v].lat + 1; n++) begin
        tick();
        if (n < vecs[v].lat) chk("vec_early_done", 32'(done), 32'd0);
        if (!vecs[v].imm && n == 1) chk("vec_rd_sel", 32'(rd_sel), 32'(vecs[v].src));
        if (n == vecs[v].lat) begin
          chk("vec_done", 32'(done), 32'd1);
          chk("vec_sbus", 32'(sbus), 32'(vecs[v].exp_sbus));
          chk("vec_sr_sel", 32'(sr_sel), 32'(vecs[v].exp_sel));
        end
        if (n == vecs[v].lat + 1) begin
          chk("vec_done_end", 32'(done), 32'd0);
          chk("vec_sr_sel_end", 32'(sr_sel), 32'd0);
          chk("vec_sbus_kept", 32'(sbus), 32'(vecs[v].exp_sbus));
          chk("vec_busy_end", 32'(busy), 32'd0);
        end
      end
    end

    // Bursts with req_valid held high.
    burst(1'b1, "imm_burst");
    burst(1'b0, "reg_burst");

    // Mixed queue: reg 1->3 followed by imm 0x5555->4.
    preload(3'd1, 16'h1357);
    drive_req(1'b0, 3'd1, 3'd3, '0);
    tick();
    drive_req(1'b1, 3'd0, 3'd4, 16'h5555);
    tick();
    req_valid = 1'b0;
    tick();
    chk("mix_drive1_sel", 32'(sr_sel), 32'h08);
    chk("mix_drive1_sbus", 32'(sbus), 32'h1357);
    tick();
    chk("mix_drive2_sel", 32'(sr_sel), 32'h10);
    chk("mix_drive2_sbus", 32'(sbus), 32'h5555);
    tick();
    chk("mix_after_sel", 32'(sr_sel), 32'd0);
    chk("mix_after_busy", 32'(busy), 32'd0);

    // Reset during FETCH of 1->3 with an immediate queued behind it.
    drive_req(1'b0, 3'd1, 3'd3, '0);
    tick();
    drive_req(1'b1, 3'd0, 3'd4, 16'h7777);
    tick();
    chk("abort_fetch_rd_sel", 32'(rd_sel), 32'd1);
    rst = 1'b1;
    drive_req(1'b1, 3'd0, 3'd6, 16'h9999);
    #1;
    chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("abort_sr_sel", 32'(sr_sel), 32'd0);
    chk("abort_sbus", 32'(sbus), 32'd0);
    chk("abort_rd_sel", 32'(rd_sel), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    begin
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (sr_sel != '0 || done) pulses++;
      end
      chk("abort_no_pulse", 32'(pulses), 32'd0);
    end

    // Randomized run against an in-order transfer model.
    for (int i = 0; i < NREG; i++) begin
      ref_rf[i] = WIDTH'($urandom);
      preload(IDXW'(i), ref_rf[i]);
    end
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_done", 32'd1, 32'd0);
        end else begin
          op_t op;
          logic [WIDTH-1:0] exp;
          op  = q.pop_front();
          exp = op.imm ? op.data : ref_rf[op.src];
          chk("rnd_sbus", 32'(sbus), 32'(exp));
          chk("rnd_sr_sel", 32'(sr_sel), 32'(8'h1 << op.dst));
          ref_rf[op.dst] = exp;
        end
      end else if (sr_sel != '0) begin
        chk("rnd_sr_sel_idle", 32'(sr_sel), 32'd0);
      end
      if (c < 350 && $urandom_range(0, 2) != 0)
        drive_req(1'($urandom), IDXW'($urandom), IDXW'($urandom), WIDTH'($urandom));
      else
        req_valid = 1'b0;
      if (req_valid && req_ready)
        q.push_back('{req_imm, req_src, req_dst, req_data});
      tick();
    end
    chk("rnd_queue_drained", 32'(q.size()), 32'd0);
    chk("rnd_busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < NREG; i++)
      chk("rnd_regfile", 32'(rf[i]), 32'(ref_rf[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
